demux_4_stream: RTL and testbench
=================================

// Module: demux_4_stream
// PURPOSE
//   Registered 1:16 stream demultiplexer; the distributing counterpart to the 16:1 mux_4 selector.
//   Routes a single valid/ready input stream to one of 16 output channels.
//   The channel is chosen by the 4-bit select ctrl0..ctrl3; ctrl0 is the MSB, so {1,0,0,0} selects channel 8.
//   Each channel has a one-entry output register with its own valid/ready handshake.
//   Sits between a shared producer and 16 independent consumers.
// PARAMETERS
//   WIDTH   8    data width per channel, in bits.
//   CNT_W   16   width of the statistics counters (DEMUX_STATS_EN only).
// PORTS
//   clk        in   1           single clock; all state updates on the rising edge.
//   rst        in   1           asynchronous, active-high reset.
//   ctrl0      in   1           select bit 3 (MSB).
//   ctrl1      in   1           select bit 2.
//   ctrl2      in   1           select bit 1.
//   ctrl3      in   1           select bit 0 (LSB).
//   in_data    in   WIDTH       input payload.
//   in_valid   in   1           input beat present.
//   in_ready   out  1           demux can accept the beat this cycle.
//   out_data   out  16*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH].
//   out_valid  out  16          per-channel output valid.
//   out_ready  in   16          per-channel consumer ready.
//   xfer_cnt   out  CNT_W       accepted-beat counter (DEMUX_STATS_EN only).
//   stall_cnt  out  CNT_W       stall-cycle counter (DEMUX_STATS_EN only).
// BEHAVIOUR
//   - Select: sel = {ctrl0,ctrl1,ctrl2,ctrl3}.
//       * Sampled only in the cycle a beat is accepted.
//       * ctrl may change freely while in_valid=1 and in_ready=0; routing follows the current ctrl.
//   - Per-channel register: each channel k holds buf[k] (WIDTH bits) and vld[k].
//       * out_data slice k = buf[k]; out_valid[k] = vld[k].
//   - in_ready = ~vld[sel] | out_ready[sel].
//       * Combinational path from out_ready and ctrl is allowed.
//       * There is no path from in_valid to in_ready.
//   - Accept: acc = in_valid & in_ready.
//       * On acc, buf[sel] <= in_data and vld[sel] <= 1 at the next edge.
//       * Latency is 1 cycle from input accept to output valid.
//   - Pop: when vld[k] & out_ready[k] and channel k is not being loaded, vld[k] <= 0.
//       * buf[k] holds its last value after the pop; it is not cleared.
//   - Simultaneous pop and load on the same channel: vld stays 1 and buf takes the new data.
//       * This gives full throughput: one beat per cycle per channel.
//   - Non-selected channels are unaffected by the input side; they drain independently.
//   - Output stability: while vld[k]=1 and out_ready[k]=0, buf[k] and vld[k] must not change.
//   - Reset (asynchronous, any cycle, including mid-transfer):
//       * all vld = 0, all buf = 0, counters = 0.
//       * in_ready = 1 combinationally once vld is cleared.
//       * Any beat in flight is dropped.
// CONFIGURATION
//   DEMUX_STATS_EN defined:
//     - xfer_cnt increments on every acc.
//     - stall_cnt increments on every cycle with in_valid=1 and in_ready=0.
//     - Both counters saturate at all-ones; they never wrap.
//   DEMUX_STATS_EN undefined:
//     - no counter registers are built; xfer_cnt and stall_cnt are tied to 0.
//     - ports are unchanged.
// TESTING
//   1. Reset: rst=1 mid-stream -> all out_valid=0, out_data=0, in_ready=1, counters=0.
//   2. Routing: ctrl={1,0,1,1}, in_data=8'hA5, in_valid=1 for 1 cycle
//      -> next cycle out_valid=16'h0800, out_data[11*8+:8]=8'hA5.
//   3. Backpressure: channel 3 full with out_ready[3]=0, sel=3, in_valid=1
//      -> in_ready=0 and buf[3] stable; with DEMUX_STATS_EN, stall_cnt +1 per cycle.
//      Then out_ready[3]=1 -> accept in the same cycle, new data visible next cycle.
//   4. Streaming: sel=0, out_ready[0]=1, 8 back-to-back beats 1..8
//      -> out_data[7:0] shows 1..8 on consecutive cycles, no bubbles; xfer_cnt=8.
//   5. Independence: channel 5 full and stalled, sel switches to 6 -> beat accepted into channel 6; channel 5 is untouched.
//   6. Saturation (CNT_W=4, DEMUX_STATS_EN): 20 accepted beats -> xfer_cnt=4'hF.

Source files
------------

// File: rtl/demux_4_stream_if.sv
// Stream bundle for demux_4_stream: one shared input stream and 16 output channels.
// The slave modport is the demux side and the master modport is the producer/consumer side.
interface demux_4_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [16*WIDTH-1:0] out_data;
  logic [15:0]         out_valid;
  logic [15:0]         out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/demux_4_stream.sv
// demux_4_stream: registered 1:16 stream demultiplexer.
// A single valid/ready input stream is routed to one of 16 channels.
// sel = {ctrl0, ctrl1, ctrl2, ctrl3}, and ctrl0 is the MSB.
// Each channel has a one-entry output register with its own handshake.
// The optional macro DEMUX_STATS_EN builds saturating xfer_cnt and stall_cnt counters.
// When the macro is undefined, both counters are tied to zero and the ports are unchanged.
module demux_4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl0,
  input  logic                ctrl1,
  input  logic                ctrl2,
  input  logic                ctrl3,
  demux_4_stream_if.slave     bus,
  output logic [CNT_W-1:0]    xfer_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [3:0]             sel;
  logic [15:0]            vld_q;
  logic [15:0][WIDTH-1:0] data_q;
  logic [15:0]            load;
  logic                   acc;

  assign sel = {ctrl0, ctrl1, ctrl2, ctrl3};

  // A slot is free when it is empty or it drains in this same cycle.
  // This gives full throughput per channel.
  assign bus.in_ready = ~vld_q[sel] | bus.out_ready[sel];
  assign acc          = bus.in_valid & bus.in_ready;

  // One-hot load strobe for the selected channel, asserted only when a beat is accepted.
  always_comb begin
    load = '0;
    if (acc) load[sel] = 1'b1;
  end

  // Per-channel output registers. A load wins over a pop, so vld stays set.
  // The data is kept after a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.in_data;
          vld_q[k]  <= 1'b1;
        end else if (vld_q[k] && bus.out_ready[k]) begin
          vld_q[k]  <= 1'b0;
        end
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] xfer_q;
  logic [CNT_W-1:0] stall_q;
  logic             stall;

  assign stall = bus.in_valid & ~bus.in_ready;

  // Saturating counters for accepted beats and for cycles where the input stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (acc && (xfer_q != '1))    xfer_q  <= xfer_q + CNT_W'(1);
      if (stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`else
  assign xfer_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed testbench for demux_4_stream.
// The counters are built with CNT_W=4 so that saturation can be reached quickly.
module tb_demux_4_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ctrl0, ctrl1, ctrl2, ctrl3;
  logic [CNT_W-1:0] xfer_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_xfer  = 0;
  int exp_stall = 0;

  demux_4_stream_if #(.WIDTH(WIDTH)) bus ();

  demux_4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl0     (ctrl0),
    .ctrl1     (ctrl1),
    .ctrl2     (ctrl2),
    .ctrl3     (ctrl3),
    .bus       (bus),
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected counter value: saturating when statistics are built, otherwise zero.
  function automatic logic [CNT_W-1:0] cnt_exp(input int n);
    logic [CNT_W-1:0] r;
    r = (n >= (2**CNT_W - 1)) ? '1 : CNT_W'(n);
`ifndef DEMUX_STATS_EN
    r = '0;
`endif
    return r;
  endfunction

  task automatic set_sel(input logic [3:0] s);
    {ctrl0, ctrl1, ctrl2, ctrl3} = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_xfer  = 0;
    exp_stall = 0;
  endtask

  task automatic test_reset;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL reset_init_valid got=%h want=%h", bus.out_valid, 16'h0000); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_init_ready got=%b want=1", bus.in_ready); end
    set_sel(4'd2);
    bus.in_data = 8'h5A; bus.in_valid = 1'b1;
    tick;
    total++; if (bus.out_valid !== 16'h0004) begin bad++; $display("FAIL reset_preload_valid got=%h want=%h", bus.out_valid, 16'h0004); end
    // A beat is stalled on channel 2 when the reset hits asynchronously between edges.
    bus.in_data = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL reset_mid_valid got=%h want=%h", bus.out_valid, 16'h0000); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_mid_data got=%h want=0", bus.out_data); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b want=1", bus.in_ready); end
    total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL reset_mid_xfer got=%h want=0", xfer_cnt); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_mid_stall got=%h want=0", stall_cnt); end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_xfer = 0; exp_stall = 0;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL reset_after_valid got=%h want=%h", bus.out_valid, 16'h0000); end
  endtask

  task automatic test_routing;
    set_sel(4'b1011);
    bus.in_data = 8'hA5; bus.in_valid = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%b want=1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    exp_xfer++;
    total++; if (bus.out_valid !== 16'h0800) begin bad++; $display("FAIL route_valid got=%h want=%h", bus.out_valid, 16'h0800); end
    total++; if (bus.out_data[11*8 +: 8] !== 8'hA5) begin bad++; $display("FAIL route_data got=%h want=%h", bus.out_data[11*8 +: 8], 8'hA5); end
    bus.out_ready[11] = 1'b1;
    tick;
    bus.out_ready[11] = 1'b0;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL route_pop_valid got=%h want=%h", bus.out_valid, 16'h0000); end
    total++; if (bus.out_data[11*8 +: 8] !== 8'hA5) begin bad++; $display("FAIL route_pop_hold got=%h want=%h", bus.out_data[11*8 +: 8], 8'hA5); end
    total++; if (xfer_cnt !== cnt_exp(exp_xfer)) begin bad++; $display("FAIL route_xfer got=%h want=%h", xfer_cnt, cnt_exp(exp_xfer)); end
  endtask

  task automatic test_backpressure;
    set_sel(4'd3);
    bus.in_data = 8'h33; bus.in_valid = 1'b1;
    tick;
    exp_xfer++;
    bus.in_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low cyc=%0d got=%b want=0", i, bus.in_ready); end
      tick;
      exp_stall++;
      total++; if (bus.out_data[3*8 +: 8] !== 8'h33) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, bus.out_data[3*8 +: 8], 8'h33); end
      total++; if (bus.out_valid !== 16'h0008) begin bad++; $display("FAIL bp_valid cyc=%0d got=%h want=%h", i, bus.out_valid, 16'h0008); end
    end
    bus.out_ready[3] = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
    tick;
    exp_xfer++;
    bus.in_valid = 1'b0; bus.out_ready[3] = 1'b0;
    total++; if (bus.out_data[3*8 +: 8] !== 8'h44) begin bad++; $display("FAIL bp_new_data got=%h want=%h", bus.out_data[3*8 +: 8], 8'h44); end
    total++; if (bus.out_valid !== 16'h0008) begin bad++; $display("FAIL bp_new_valid got=%h want=%h", bus.out_valid, 16'h0008); end
    total++; if (xfer_cnt !== cnt_exp(exp_xfer)) begin bad++; $display("FAIL bp_xfer got=%h want=%h", xfer_cnt, cnt_exp(exp_xfer)); end
    total++; if (stall_cnt !== cnt_exp(exp_stall)) begin bad++; $display("FAIL bp_stall got=%h want=%h", stall_cnt, cnt_exp(exp_stall)); end
    bus.out_ready[3] = 1'b1;
    tick;
    bus.out_ready[3] = 1'b0;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL bp_drain got=%h want=%h", bus.out_valid, 16'h0000); end
  endtask

  task automatic test_streaming;
    apply_reset;
    set_sel(4'd0);
    bus.out_ready[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_data = 8'(i); bus.in_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready beat=%0d got=%b want=1", i, bus.in_ready); end
      tick;
      exp_xfer++;
      total++; if (bus.out_data[7:0] !== 8'(i)) begin bad++; $display("FAIL stream_data beat=%0d got=%h want=%h", i, bus.out_data[7:0], 8'(i)); end
      total++; if (bus.out_valid !== 16'h0001) begin bad++; $display("FAIL stream_valid beat=%0d got=%h want=%h", i, bus.out_valid, 16'h0001); end
    end
    bus.in_valid = 1'b0;
    tick;
    bus.out_ready[0] = 1'b0;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL stream_empty got=%h want=%h", bus.out_valid, 16'h0000); end
    total++; if (xfer_cnt !== cnt_exp(8)) begin bad++; $display("FAIL stream_xfer got=%h want=%h", xfer_cnt, cnt_exp(8)); end
  endtask

  task automatic test_independence;
    set_sel(4'd5);
    bus.in_data = 8'h55; bus.in_valid = 1'b1;
    tick;
    exp_xfer++;
    bus.in_data = 8'h66;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL indep_stall_ready got=%b want=0", bus.in_ready); end
    tick;
    exp_stall++;
    set_sel(4'd6);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL indep_switch_ready got=%b want=1", bus.in_ready); end
    tick;
    exp_xfer++;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 16'h0060) begin bad++; $display("FAIL indep_valid got=%h want=%h", bus.out_valid, 16'h0060); end
    total++; if (bus.out_data[5*8 +: 8] !== 8'h55) begin bad++; $display("FAIL indep_ch5 got=%h want=%h", bus.out_data[5*8 +: 8], 8'h55); end
    total++; if (bus.out_data[6*8 +: 8] !== 8'h66) begin bad++; $display("FAIL indep_ch6 got=%h want=%h", bus.out_data[6*8 +: 8], 8'h66); end
    total++; if (xfer_cnt !== cnt_exp(exp_xfer)) begin bad++; $display("FAIL indep_xfer got=%h want=%h", xfer_cnt, cnt_exp(exp_xfer)); end
    total++; if (stall_cnt !== cnt_exp(exp_stall)) begin bad++; $display("FAIL indep_stall got=%h want=%h", stall_cnt, cnt_exp(exp_stall)); end
    bus.out_ready = 16'h0060;
    tick;
    bus.out_ready = 16'h0000;
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL indep_drain got=%h want=%h", bus.out_valid, 16'h0000); end
  endtask

  task automatic test_saturation;
    apply_reset;
    set_sel(4'd0);
    bus.out_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'h10 + 8'(i); bus.in_valid = 1'b1;
      tick;
      exp_xfer++;
    end
    bus.in_valid = 1'b0;
    tick;
    bus.out_ready[0] = 1'b0;
    total++; if (xfer_cnt !== cnt_exp(exp_xfer)) begin bad++; $display("FAIL sat_xfer got=%h want=%h", xfer_cnt, cnt_exp(exp_xfer)); end
    total++; if (stall_cnt !== cnt_exp(0)) begin bad++; $display("FAIL sat_stall got=%h want=%h", stall_cnt, cnt_exp(0)); end
    total++; if (bus.out_data[7:0] !== 8'h23) begin bad++; $display("FAIL sat_last_data got=%h want=%h", bus.out_data[7:0], 8'h23); end
    total++; if (bus.out_valid !== 16'h0000) begin bad++; $display("FAIL sat_valid got=%h want=%h", bus.out_valid, 16'h0000); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_sel(4'd0);
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset;
    test_routing;
    test_backpressure;
    test_streaming;
    test_independence;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
